// File: rtl/mux_func_scan.sv
// Mux-based function evaluator: a 2^SEL_W entry residue-code table drives direct
// evaluation of f(vars), or a scan that captures the complete truth table into tt.
module mux_func_scan #(
  parameter int SEL_W = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [SEL_W-1:0]             cfg_idx,
  input  logic [1:0]                   cfg_code,
  input  logic [SEL_W:0]               vars,
  input  logic                         mode,
  input  logic                         start,
  output logic                         y,
  output logic                         y_valid,
  output logic                         busy,
  output logic                         done,
  output logic [2**(SEL_W+1)-1:0]      tt
);
  localparam int V = SEL_W + 1;
  localparam int N = 2**SEL_W;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     code [N];
  logic [V-1:0]   cnt;
  logic           scan_go;
  logic           f_direct;
  logic           f_scan;

  function automatic logic decode(input logic [1:0] c, input logic d);
    case (c)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return d;
      default: return ~d;
    endcase
  endfunction

  assign scan_go  = (state == IDLE) && start && mode;
  assign f_direct = decode(code[vars[V-1:1]], vars[0]);
  assign f_scan   = decode(code[cnt[V-1:1]], cnt[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (scan_go) state_nxt = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (cnt == {V{1'b1}}) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table writes land only in IDLE; a same-cycle evaluation still sees the old code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tt      <= '0;
      y       <= 1'b0;
      y_valid <= 1'b0;
      for (int i = 0; i < N; i++) code[i] <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) code[cfg_idx] <= cfg_code;
          if (scan_go) begin
            cnt     <= '0;
            y_valid <= 1'b0;
          end else if (!mode) begin
            y       <= f_direct;
            y_valid <= 1'b1;
          end
        end
        SCAN: begin
          tt[cnt] <= f_scan;
          y       <= f_scan;
          cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_func_scan.sv
// Directed bench for mux_func_scan: a reference code table predicts y and tt,
// expectations go through a scoreboard queue and are compared after each edge.
module tb_mux_func_scan;
  localparam int SEL_W = 3;
  localparam int V = SEL_W + 1;
  localparam int N = 2**SEL_W;
  localparam int T = 2**V;

  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, mode = 1'b0, start = 1'b0;
  logic [SEL_W-1:0] cfg_idx = '0;
  logic [1:0]       cfg_code = '0;
  logic [V-1:0]     vars = '0;
  logic             y, y_valid, busy, done;
  logic [T-1:0]     tt;

  int tests = 0;
  int fails = 0;
  logic [1:0]   mcode [N];
  logic [T-1:0] exp_q [$];

  always #5 clk = ~clk;

  mux_func_scan #(.SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .vars(vars), .mode(mode), .start(start), .y(y), .y_valid(y_valid),
    .busy(busy), .done(done), .tt(tt)
  );

  function automatic logic fm(input logic [SEL_W-1:0] s, input logic d);
    case (mcode[s])
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return d;
      default: return ~d;
    endcase
  endfunction

  function automatic logic [T-1:0] model_tt();
    logic [T-1:0] r;
    logic [V-1:0] iv;
    for (int i = 0; i < T; i++) begin
      iv = i[V-1:0];
      r[i] = fm(iv[V-1:1], iv[0]);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [T-1:0] obs, input logic [T-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [SEL_W-1:0] idx, input logic [1:0] c);
    cfg_we = 1'b1; cfg_idx = idx; cfg_code = c;
    tick();
    cfg_we = 1'b0;
    mcode[idx] = c;
  endtask

  task automatic program_table();
    logic [1:0] tbl [N];
    tbl = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11};
    mode = 1'b1;
    for (int i = 0; i < N; i++) cfg_write(i[SEL_W-1:0], tbl[i]);
  endtask

  task automatic run_scan(input string tag, input bit disturb);
    int cycles;
    mode = 1'b1; start = 1'b1;
    exp_q.push_back(model_tt());
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin
      if (disturb && cycles == 3) begin
        cfg_we = 1'b1; cfg_idx = 3'd4; cfg_code = 2'b01; start = 1'b1; mode = 1'b0;
      end else if (disturb && cycles == 4) begin
        cfg_we = 1'b0; start = 1'b0; mode = 1'b1;
      end else if (disturb && cycles == 9) begin
        mode = 1'b0;
      end
      tick();
      cycles++;
    end
    mode = 1'b0;
    check({tag, "_busy_cycles"}, T'(cycles), T'(16));
    check({tag, "_done_pulse"}, T'(done), T'(1));
    check({tag, "_tt_model"}, tt, exp_q.pop_front());
    check({tag, "_tt_const"}, tt, 16'h48A5);
    tick();
    check({tag, "_done_low"}, T'(done), T'(0));
  endtask

  initial begin
    int done_seen;
    for (int i = 0; i < N; i++) mcode[i] = 2'b00;
    #12;
    check("rst_outs", {tt[12:0], y, y_valid, busy, done}, '0);
    rst_n = 1'b1;
    #3;

    // all codes 00 -> y=0, valid one cycle later
    mode = 1'b0; vars = 4'b0110;
    exp_q.push_back(T'(fm(vars[V-1:1], vars[0])));
    tick();
    check("post_rst_y", T'(y), exp_q.pop_front());
    check("post_rst_valid", T'(y_valid), T'(1));

    // start ignored with mode=0
    start = 1'b1; tick(); start = 1'b0;
    check("start_mode0_busy", T'(busy), T'(0));

    program_table();
    check("idle_mode1_valid", T'(y_valid), T'(1));
    run_scan("scan1", 1'b0);
    check("after_scan_valid", T'(y_valid), T'(0));

    mode = 1'b0;
    for (int v = 0; v < T; v++) begin
      vars = v[V-1:0];
      exp_q.push_back(T'(fm(vars[V-1:1], vars[0])));
      tick();
      check($sformatf("direct_v%0d", v), T'(y), exp_q.pop_front());
    end
    check("direct_valid", T'(y_valid), T'(1));

    run_scan("scan_dist", 1'b1);
    run_scan("scan_again", 1'b0);

    // reset at scan cycle 8
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("mid_scan_busy", T'(busy), T'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {tt[12:0], y, y_valid, busy, done}, '0);
    for (int i = 0; i < N; i++) mcode[i] = 2'b00;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) done_seen++;
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) done_seen++;
    end
    check("no_done_after_rst", T'(done_seen), T'(0));
    check("tt_zero_after_rst", tt, model_tt() & '0);
    program_table();
    run_scan("rescan", 1'b0);

    // config write same cycle as evaluation uses old code
    mode = 1'b0; vars = 4'b0001;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_code = 2'b01;
    exp_q.push_back(T'(fm(3'd0, 1'b1)));
    tick();
    cfg_we = 1'b0;
    mcode[0] = 2'b01;
    check("cfg_old_code", T'(y), exp_q.pop_front());
    exp_q.push_back(T'(fm(3'd0, 1'b1)));
    tick();
    check("cfg_new_code", T'(y), exp_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_func_scan.md
MUX_FUNC_SCAN -- requirements
Module: mux_func_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, giving the mux select width; the mux has N=2^SEL_W data inputs and evaluates V=SEL_W+1 variables.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port cfg_we, input, 1 bit: writes cfg_code into table entry cfg_idx.
REQ-005 The block SHALL have port cfg_idx, input, SEL_W bits: index of the data input being configured.
REQ-006 The block SHALL have port cfg_code, input, 2 bits: residue code, 00=const 0, 01=const 1, 10=D, 11=~D.
REQ-007 The block SHALL have port vars, input, V bits: vars[V-1:1] form the mux select (MSB = first variable) and vars[0] is the residual variable D.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = direct evaluation, 1 = truth-table scan.
REQ-009 The block SHALL have port start, input, 1 bit: launches a scan when mode=1.
REQ-010 The block SHALL have port y, output, 1 bit: registered function value.
REQ-011 The block SHALL have port y_valid, output, 1 bit: y holds a direct-mode result.
REQ-012 The block SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at scan completion.
REQ-014 The block SHALL have port tt, output, 2^V bits: captured truth table, where tt[i] = f(i) and i = {select, D}.

Function
REQ-015 The block SHALL define f(s,d) as the decode of code[s]: 00 gives 0, 01 gives 1, 10 gives d, 11 gives ~d.
REQ-016 The block SHALL have FSM states IDLE, SCAN and DONE.
REQ-017 In IDLE with mode=0, the block SHALL register y <= f(vars) every cycle and set y_valid=1 from the cycle after, giving 1-cycle latency.
REQ-018 In IDLE, the block SHALL load a config write (cfg_we=1) at the clock edge; an evaluation in the same cycle SHALL use the old code, so the new code affects y from the next evaluation.
REQ-019 In IDLE, when start=1 and mode=1, the block SHALL go to SCAN, clear the counter cnt (V bits) to 0, and set busy=1 and y_valid=0 from the next cycle.
REQ-020 In SCAN, on each cycle the block SHALL write tt[cnt] <= f(cnt[V-1:1], cnt[0]) and y <= the same value, then increment cnt.
REQ-021 In SCAN, when cnt = 2^V-1 the block SHALL write the last entry and go to DONE, so SCAN lasts exactly 2^V cycles.
REQ-022 In DONE, the block SHALL hold done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-023 The block SHALL sample mode only in IDLE; changing mode during SCAN or DONE SHALL have no effect.
REQ-024 The block SHALL ignore start while in SCAN or DONE, with no restart.
REQ-025 The block SHALL ignore cfg_we while in SCAN or DONE: the table stays unchanged and the write is dropped, not queued.
REQ-026 The block SHALL keep tt bits until overwritten by a later scan; tt is not cleared at scan start.
REQ-027 The block SHALL ignore start when mode=0 and stay in direct mode.
REQ-028 The block SHALL drive y_valid=0 in SCAN and DONE; y_valid SHALL go to 1 again one cycle after IDLE evaluation resumes with mode=0.
REQ-029 When start=1 and mode=1 in IDLE, the scan SHALL take priority over direct evaluation, and y SHALL keep its old value for that cycle.

Reset
REQ-030 On rst_n=0, the block SHALL immediately, without waiting for clk, set state=IDLE, cnt=0, all table codes=00, tt=0, y=0, y_valid=0, busy=0 and done=0.
REQ-031 If reset is asserted mid-scan, the block SHALL abort the scan with no done pulse, and tt SHALL read 0.
REQ-032 After rst_n rises, the block SHALL resume operation on the first rising clk edge.

Verification (SEL_W=3)
REQ-033 Bench scenario: after reset, with mode=0, drive any vars -> y=0 and y_valid=1 one cycle later, because every code is 00.
REQ-034 Bench scenario: program codes I0..I7 = 11,11,10,10,00,10,00,11, then run a scan -> busy for 16 cycles, done pulses in cycle 17 after start, and tt=16'h48A5.
REQ-035 Bench scenario: with the same table, mode=0, step vars through 0000..1111 -> y tracks tt[vars] with 1-cycle latency (e.g. vars=0101 gives y=1; vars=1000 gives y=0).
REQ-036 Bench scenario: during a scan, pulse cfg_we (idx 4, code 01) and start, and toggle mode -> scan still completes with tt=16'h48A5, and a later scan also gives 16'h48A5.
REQ-037 Bench scenario: assert rst_n=0 at scan cycle 8 -> all outputs go to 0 immediately and no done pulse occurs; re-program the table and rescan -> tt=16'h48A5.
REQ-038 Bench scenario: in IDLE, write cfg idx 0 code 01 while vars=0001 -> y=0 on the first edge (old code 11 with D=1) and y=1 on the next edge.
